ha_array_sum_pipe: RTL and testbench



---
 rtl/ha_array_sum_pipe_pkg.sv | 22 ++
 rtl/ha_array_sum_pipe_if.sv | 40 ++++
 rtl/ha_array_sum_pipe_stage.sv | 31 +++
 rtl/ha_array_sum_pipe.sv | 96 +++++++++
 tb/tb_ha_array_sum_pipe.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ha_array_sum_pipe_pkg.sv
// Shared widths, row record and row weighting helper for the 8x8 multiplier
// half-adder reduction path.
package mul8_pkg;

  localparam int HA_T_W = 9;
  localparam int HA_B_W = 7;
  localparam int ROW_W  = 10;
  localparam int PAIR_W = 13;
  localparam int NROWS  = 4;

  typedef struct packed {
    logic [HA_T_W-1:0] t;
    logic [HA_B_W-1:0] b;
  } ha_row_t;

  // Collapse one half-adder row to its unsigned value: the carry vector sits
  // two bit positions above the sum vector.
  function automatic logic [ROW_W-1:0] row_value(input ha_row_t r);
    return ROW_W'(r.t) + (ROW_W'(r.b) << 2);
  endfunction

endpackage

// File: rtl/ha_array_sum_pipe_if.sv
// Operand/result handshake bundle for ha_array_sum_pipe.
interface ha_array_sum_pipe_if #(
  parameter int TAG_W  = 4,
  parameter int PROD_W = 17
);
  import mul8_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [HA_B_W-1:0] ha_array_0_b;
  logic [HA_B_W-1:0] ha_array_1_b;
  logic [HA_B_W-1:0] ha_array_2_b;
  logic [HA_B_W-1:0] ha_array_3_b;
  logic [HA_T_W-1:0] ha_array_0_t;
  logic [HA_T_W-1:0] ha_array_1_t;
  logic [HA_T_W-1:0] ha_array_2_t;
  logic [HA_T_W-1:0] ha_array_3_t;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [PROD_W-1:0] prod;

  modport master (
    output in_valid, in_tag,
    output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    output out_ready,
    input  in_ready, out_valid, out_tag, prod
  );

  modport slave (
    input  in_valid, in_tag,
    input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    input  out_ready,
    output in_ready, out_valid, out_tag, prod
  );

endinterface

// File: rtl/ha_array_sum_pipe_stage.sv
// Generic valid/ready register slice. A slice advances when it is empty or
// when its downstream neighbour advances, so bubbles collapse upstream.
module ha_pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dn_adv,
  output logic              adv,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out
);

  assign adv = !vld_out || dn_adv;

  // Capture on advance; data loads only with a valid set so idle inputs never leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out  <= 1'b0;
      data_out <= '0;
    end else if (adv) begin
      vld_out <= vld_in;
      if (vld_in) begin
        data_out <= data_in;
      end
    end
  end

endmodule

// File: rtl/ha_array_sum_pipe.sv
// Reduces the four half-adder rows of the approximate 8x8 multiplier to the
// final product in three registered stages with valid/ready flow control.
module ha_array_sum_pipe
  import mul8_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int PROD_W = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  ha_array_sum_pipe_if.slave bus
);

  generate
    if (PROD_W < 17) begin : g_prod_w_chk
      $error("ha_array_sum_pipe: PROD_W must be at least 17");
    end
  endgenerate

  localparam int D0_W = NROWS * ROW_W + TAG_W;
  localparam int D1_W = 2 * PAIR_W + TAG_W;
  localparam int D2_W = PROD_W + TAG_W;

  function automatic logic [PAIR_W-1:0] pair_sum(input logic [ROW_W-1:0] lo,
                                                 input logic [ROW_W-1:0] hi);
    return PAIR_W'(lo) + (PAIR_W'(hi) << 2);
  endfunction

  function automatic logic [PROD_W-1:0] prod_sum(input logic [PAIR_W-1:0] lo,
                                                 input logic [PAIR_W-1:0] hi);
    return PROD_W'(lo) + (PROD_W'(hi) << 4);
  endfunction

  ha_row_t [NROWS-1:0] row_in;
  assign row_in[0] = {bus.ha_array_0_t, bus.ha_array_0_b};
  assign row_in[1] = {bus.ha_array_1_t, bus.ha_array_1_b};
  assign row_in[2] = {bus.ha_array_2_t, bus.ha_array_2_b};
  assign row_in[3] = {bus.ha_array_3_t, bus.ha_array_3_b};

  logic              adv_p0, adv_p1, adv_p2;
  logic              vld_p0, vld_p1, vld_p2;
  logic [D0_W-1:0]   d_in_p0, d_p0;
  logic [D1_W-1:0]   d_in_p1, d_p1;
  logic [D2_W-1:0]   d_in_p2, d_p2;
  logic [ROW_W-1:0]  r0_p0, r1_p0, r2_p0, r3_p0;
  logic [TAG_W-1:0]  tag_p0, tag_p1;
  logic [PAIR_W-1:0] pa_p1, pb_p1;

  // ---- stage p0: weight each row and accept the operand set ----
  assign d_in_p0 = {bus.in_tag,
                    row_value(row_in[3]), row_value(row_in[2]),
                    row_value(row_in[1]), row_value(row_in[0])};

  ha_pipe_stage #(.DATA_W(D0_W)) u_stage_p0 (
    .clk(clk), .rst_n(rst_n),
    .vld_in(bus.in_valid), .data_in(d_in_p0),
    .dn_adv(adv_p1), .adv(adv_p0),
    .vld_out(vld_p0), .data_out(d_p0)
  );

  assign r0_p0  = d_p0[0*ROW_W +: ROW_W];
  assign r1_p0  = d_p0[1*ROW_W +: ROW_W];
  assign r2_p0  = d_p0[2*ROW_W +: ROW_W];
  assign r3_p0  = d_p0[3*ROW_W +: ROW_W];
  assign tag_p0 = d_p0[D0_W-1 -: TAG_W];

  // ---- stage p1: combine rows pairwise (rows 0/1 and 2/3) ----
  assign d_in_p1 = {tag_p0, pair_sum(r2_p0, r3_p0), pair_sum(r0_p0, r1_p0)};

  ha_pipe_stage #(.DATA_W(D1_W)) u_stage_p1 (
    .clk(clk), .rst_n(rst_n),
    .vld_in(vld_p0), .data_in(d_in_p1),
    .dn_adv(adv_p2), .adv(adv_p1),
    .vld_out(vld_p1), .data_out(d_p1)
  );

  assign pa_p1  = d_p1[0 +: PAIR_W];
  assign pb_p1  = d_p1[PAIR_W +: PAIR_W];
  assign tag_p1 = d_p1[D1_W-1 -: TAG_W];

  // ---- stage p2: final sum, held at the output until consumed ----
  assign d_in_p2 = {tag_p1, prod_sum(pa_p1, pb_p1)};

  ha_pipe_stage #(.DATA_W(D2_W)) u_stage_p2 (
    .clk(clk), .rst_n(rst_n),
    .vld_in(vld_p1), .data_in(d_in_p2),
    .dn_adv(bus.out_ready), .adv(adv_p2),
    .vld_out(vld_p2), .data_out(d_p2)
  );

  assign bus.in_ready  = adv_p0;
  assign bus.out_valid = vld_p2;
  assign bus.prod      = d_p2[PROD_W-1:0];
  assign bus.out_tag   = d_p2[D2_W-1 -: TAG_W];

endmodule

// File: tb/tb_ha_array_sum_pipe.sv
// Bench for ha_array_sum_pipe: constant-table single sets, random streaming,
// backpressure and mid-stream reset, with a queue scoreboard on the output.
module tb_ha_array_sum_pipe;
  import mul8_pkg::*;

  typedef struct {
    logic [3:0]  tag;
    logic [16:0] prod;
  } exp_t;

  typedef struct {
    ha_row_t [3:0] r;
    logic [3:0]    tag;
    logic [16:0]   exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_in = 0;
  int   n_out = 0;
  exp_t sb[$];
  exp_t mon_e;
  ha_row_t [3:0] mon_r;

  always #5 clk = ~clk;

  ha_array_sum_pipe_if #(.TAG_W(4), .PROD_W(17)) bus ();

  ha_array_sum_pipe #(.TAG_W(4), .PROD_W(17)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input ha_row_t [3:0] r);
    logic [16:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s = s + (17'(row_value(r[k])) << (2 * k));
    return s;
  endfunction

  task automatic drive_set(input ha_row_t [3:0] r, input logic [3:0] tag);
    bus.ha_array_0_t = r[0].t; bus.ha_array_0_b = r[0].b;
    bus.ha_array_1_t = r[1].t; bus.ha_array_1_b = r[1].b;
    bus.ha_array_2_t = r[2].t; bus.ha_array_2_b = r[2].b;
    bus.ha_array_3_t = r[3].t; bus.ha_array_3_b = r[3].b;
    bus.in_tag = tag;
  endtask

  function automatic ha_row_t [3:0] rand_rows();
    ha_row_t [3:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k].t = 9'($urandom);
      r[k].b = 7'($urandom);
    end
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One isolated set with out_ready high; checks latency, product and tag.
  task automatic send_one(input string name, input ha_row_t [3:0] r,
                          input logic [3:0] tag, input logic [16:0] exp);
    int lat;
    bit seen;
    drive_set(r, tag);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drive_set(rand_rows(), 4'($urandom));
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'd2);
    if (seen) begin
      check({name, "_prod"}, 32'(bus.prod), 32'(exp));
      check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    end
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (sb.size() != 0 && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({name, "_in_eq_out"}, 32'(n_out), 32'(n_in));
  endtask

  // Scoreboard: push the model result on every accepted set, pop and compare on every emitted product.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_prod", 32'(bus.prod), 32'(mon_e.prod));
          check("sb_tag", 32'(bus.out_tag), 32'(mon_e.tag));
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_r[0] = {bus.ha_array_0_t, bus.ha_array_0_b};
        mon_r[1] = {bus.ha_array_1_t, bus.ha_array_1_b};
        mon_r[2] = {bus.ha_array_2_t, bus.ha_array_2_b};
        mon_r[3] = {bus.ha_array_3_t, bus.ha_array_3_b};
        mon_e.tag  = bus.in_tag;
        mon_e.prod = model(mon_r);
        sb.push_back(mon_e);
        n_in++;
      end
    end
  end

  vec_t          tbl[9];
  ha_row_t [3:0] bp[5];
  ha_row_t [3:0] rr;
  logic [16:0]   held_prod;
  logic [3:0]    held_tag;
  int            acc;
  int            snap;
  bit            will;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rr = '0;
    drive_set(rr, 4'd0);

    for (int i = 0; i < 9; i++) tbl[i].r = '0;
    tbl[0].r[0].t = 9'h001;  tbl[0].tag = 4'h5; tbl[0].exp = 17'd1;
    tbl[1].r[3].b = 7'h40;   tbl[1].tag = 4'h6; tbl[1].exp = 17'd16384;
    tbl[2].r[2].t = 9'h100;  tbl[2].tag = 4'h7; tbl[2].exp = 17'd4096;
    for (int k = 0; k < 4; k++) begin
      tbl[3].r[k].t = 9'h1FF;
      tbl[3].r[k].b = 7'h7F;
    end
    tbl[3].tag = 4'hF; tbl[3].exp = 17'h15257;
    tbl[4].r[1].b = 7'h01;   tbl[4].tag = 4'h1; tbl[4].exp = 17'd16;
    tbl[5].r[1].t = 9'h100;  tbl[5].tag = 4'h2; tbl[5].exp = 17'd1024;
    tbl[6].r[0].b = 7'h40;   tbl[6].tag = 4'h3; tbl[6].exp = 17'd256;
    tbl[7].r[3].t = 9'h001;  tbl[7].tag = 4'h0; tbl[7].exp = 17'd64;
    tbl[8].r[0].t = 9'h003;  tbl[8].r[2].b = 7'h02;
    tbl[8].tag = 4'h9; tbl[8].exp = 17'd131;

    // reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_prod", 32'(bus.prod), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // table of isolated sets
    for (int i = 0; i < 9; i++) begin
      send_one($sformatf("vec%0d", i), tbl[i].r, tbl[i].tag, tbl[i].exp);
    end
    idle(2);
    drain("table");

    // back-to-back random stream
    bus.out_ready = 1'b1;
    snap = n_out;
    for (int i = 0; i < 100; i++) begin
      drive_set(rand_rows(), 4'($urandom));
      bus.in_valid = 1'b1;
      if (!bus.in_ready) check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("stream_throughput", 32'(n_out - snap), 32'd97);
    drain("stream");

    // backpressure: 5 sets against a stalled output
    idle(1);
    for (int i = 0; i < 5; i++) bp[i] = rand_rows();
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive_set(bp[acc], 4'(acc + 8));
      bus.in_valid = 1'b1;
      will = bus.in_ready;
      @(posedge clk);
      #1;
      if (will) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd3);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_head_prod", 32'(bus.prod), 32'(model(bp[0])));
    check("bp_head_tag", 32'(bus.out_tag), 32'd8);
    held_prod = bus.prod;
    held_tag  = bus.out_tag;
    idle(3);
    check("bp_prod_stable", 32'(bus.prod), 32'(held_prod));
    check("bp_tag_stable", 32'(bus.out_tag), 32'(held_tag));
    check("bp_still_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && acc < 5; c++) begin
      drive_set(bp[acc], 4'(acc + 8));
      bus.in_valid = 1'b1;
      will = bus.in_ready;
      @(posedge clk);
      #1;
      if (will) acc++;
    end
    bus.in_valid = 1'b0;
    check("bp_all_accepted", 32'(acc), 32'd5);
    drain("bp");

    // asynchronous reset with three sets in flight
    idle(1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_set(rand_rows(), 4'(i + 12));
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_prod", 32'(bus.prod), 32'd0);
    check("mid_rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    n_in  = 0;
    n_out = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) check("mid_stale_output", 32'(bus.out_valid), 32'd0);
    end
    check("mid_quiet", 32'(n_out), 32'd0);
    rr = '0;
    rr[0].t = 9'h005;
    rr[1].b = 7'h01;
    send_one("after_rst", rr, 4'hA, 17'd21);
    idle(2);
    drain("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
